// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch (IF) and load/store (LS).
// Define ARB_ROUND_ROBIN_EN to replace LS-priority/starvation arbitration with round robin.
module unified_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2,
    parameter int STARVE_MAX  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    typedef enum logic { S_IDLE, S_WAIT } state_t;
    typedef enum logic { OWN_IF, OWN_LS } owner_t;

    state_t             state;
    owner_t             owner;
    logic [CNT_W-1:0]   cnt;
    logic               flushed;
    logic               ls_store;
    logic               armed;

    logic               arb_open;
    logic               ls_wins;
    logic               issue;
    logic               issue_if;
    logic               issue_ls;
    logic               done;

    // Arbitration is held off for one cycle after reset release so every output stays quiet.
    assign arb_open = armed && (state == S_IDLE);
    assign issue    = arb_open && (if_req || ls_req);
    assign issue_ls = issue && ls_wins;
    assign issue_if = issue && !ls_wins;
    assign done     = (state == S_WAIT) && (cnt == CNT_W'(MEM_LATENCY));

`ifdef ARB_ROUND_ROBIN_EN
    owner_t last_owner;

    assign ls_wins = ls_req && (!if_req || (last_owner == OWN_IF));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_owner <= OWN_IF;
        end else if (issue) begin
            last_owner <= issue_ls ? OWN_LS : OWN_IF;
        end
    end
`else
    localparam int ST_W = $clog2(STARVE_MAX + 1);

    logic [ST_W-1:0] starve;

    assign ls_wins = ls_req && !(if_req && (starve == ST_W'(STARVE_MAX)));

    // Starvation only counts arbitration rounds; cycles spent in WAIT leave it untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve <= '0;
        end else if (arb_open) begin
            if (!if_req || issue_if) begin
                starve <= '0;
            end else if (starve != ST_W'(STARVE_MAX)) begin
                starve <= starve + 1'b1;
            end
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            owner    <= OWN_IF;
            cnt      <= '0;
            flushed  <= 1'b0;
            ls_store <= 1'b0;
            armed    <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        state    <= S_WAIT;
                        cnt      <= CNT_W'(1);
                        owner    <= issue_ls ? OWN_LS : OWN_IF;
                        ls_store <= issue_ls && ls_we;
                        flushed  <= issue_if && if_flush;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if ((owner == OWN_IF) && if_flush) begin
                        flushed <= 1'b1;
                    end
                    if (done) begin
                        state   <= S_IDLE;
                        cnt     <= '0;
                        flushed <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign if_gnt    = issue_if;
    assign ls_gnt    = issue_ls;
    assign mem_en    = issue;
    assign mem_we    = issue_ls && ls_we;
    assign mem_addr  = issue_ls ? ls_addr : (issue_if ? if_addr : '0);
    assign mem_wdata = issue_ls ? ls_wdata : '0;

    // A flushed fetch still occupies the memory for the full latency; only the pulse is dropped.
    assign if_rvalid = done && (owner == OWN_IF) && !flushed;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign ls_rvalid = done && (owner == OWN_LS);
    assign ls_rdata  = (ls_rvalid && !ls_store) ? mem_rdata : '0;
    assign busy      = (state == S_WAIT);

    a_gnt_onehot : assert property (@(posedge clk) disable iff (!reset_n)
        !(if_gnt && ls_gnt));
    a_rvalid_onehot : assert property (@(posedge clk) disable iff (!reset_n)
        !(if_rvalid && ls_rvalid));
    a_no_gnt_in_wait : assert property (@(posedge clk) disable iff (!reset_n)
        busy |-> !(if_gnt || ls_gnt || mem_en));
    a_bus_quiet : assert property (@(posedge clk) disable iff (!reset_n)
        !mem_en |-> (mem_addr == '0 && mem_wdata == '0 && !mem_we));

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: directed stimulus queues expected grants and
// responses; a negedge monitor pops and compares them whenever the DUT presents one.
module tb_unified_mem_arbiter;

    logic        clk;
    logic        reset_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    unified_mem_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          ls;
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
    } gnt_t;

    typedef struct {
        bit          ls;
        logic [31:0] data;
    } rsp_t;

    gnt_t exp_gnt[$];
    rsp_t exp_rsp[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Memory contents: address 0x4 holds the test instruction, everything else is address-derived.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h4) return 32'h00A00113;
        return {a[15:0], ~a[15:0]};
    endfunction

    logic [31:0] mem_d1;
    logic [31:0] mem_d2;
    always @(posedge clk) begin
        mem_d1 <= mem_en ? mem_val(mem_addr) : 32'hDEAD_BEEF;
        mem_d2 <= mem_d1;
    end
    assign mem_rdata = mem_d2;

    function automatic logic [63:0] outs();
        return {53'b0, if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, busy,
                |if_rdata, |ls_rdata, |mem_addr, |mem_wdata};
    endfunction

    task automatic push_if(input logic [31:0] a, input bit deliver);
        exp_gnt.push_back('{1'b0, a, 1'b0, 32'h0});
        if (deliver) exp_rsp.push_back('{1'b0, mem_val(a)});
    endtask

    task automatic push_ls(input logic [31:0] a, input bit we, input logic [31:0] wd);
        exp_gnt.push_back('{1'b1, a, we, wd});
        exp_rsp.push_back('{1'b1, we ? 32'h0 : mem_val(a)});
    endtask

    always @(negedge clk) begin
        gnt_t g;
        rsp_t r;
        if (reset_n) begin
            if (if_gnt || ls_gnt) begin
                check("gnt_pending", exp_gnt.size() != 0, 1);
                check("gnt_onehot", if_gnt && ls_gnt, 0);
                if (exp_gnt.size() != 0) begin
                    g = exp_gnt.pop_front();
                    check("gnt_who_ls", ls_gnt, g.ls);
                    check("gnt_mem_en", mem_en, 1);
                    check("gnt_mem_addr", mem_addr, g.addr);
                    check("gnt_mem_we", mem_we, g.we);
                    check("gnt_mem_wdata", mem_wdata, g.wdata);
                end
            end
            if (if_rvalid || ls_rvalid) begin
                check("rsp_pending", exp_rsp.size() != 0, 1);
                check("rsp_onehot", if_rvalid && ls_rvalid, 0);
                if (exp_rsp.size() != 0) begin
                    r = exp_rsp.pop_front();
                    check("rsp_who_ls", ls_rvalid, r.ls);
                    check("rsp_data", ls_rvalid ? ls_rdata : if_rdata, r.data);
                end
            end
        end
    end

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy && exp_rsp.size() == 0 && exp_gnt.size() == 0) break;
        end
        check({tag, "_drain_rsp"}, exp_rsp.size(), 0);
        check({tag, "_drain_gnt"}, exp_gnt.size(), 0);
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset_n  = 1'b0;
        if_req   = 1'b0;
        if_addr  = '0;
        if_flush = 1'b0;
        ls_req   = 1'b0;
        ls_we    = 1'b0;
        ls_addr  = '0;
        ls_wdata = '0;

        // Reset and quiet idle.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outs", outs(), 0);
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_outs", outs(), 0);
        end

        // Single fetch, then back-to-back fetch at T+3.
        @(posedge clk); #1 if_req = 1'b1; if_addr = 32'h4;
        exp_gnt.push_back('{1'b0, 32'h4, 1'b0, 32'h0});
        exp_rsp.push_back('{1'b0, 32'h00A00113});
        @(negedge clk);
        check("t2_gnt_T", if_gnt, 1);
        check("t2_busy_T", busy, 0);
        @(posedge clk); #1 if_req = 1'b0;
        @(negedge clk);
        check("t2_busy_T1", busy, 1);
        check("t2_mem_en_T1", mem_en, 0);
        check("t2_mem_addr_T1", mem_addr, 0);
        check("t2_rvalid_T1", if_rvalid, 0);
        @(negedge clk);
        check("t2_rvalid_T2", if_rvalid, 1);
        check("t2_rdata_T2", if_rdata, 32'h00A00113);
        @(posedge clk); #1 if_req = 1'b1; if_addr = 32'h8;
        push_if(32'h8, 1'b1);
        @(negedge clk);
        check("t2_busy_T3", busy, 0);
        check("t2_regrant_T3", if_gnt, 1);
        @(posedge clk); #1 if_req = 1'b0;
        wait_idle("t2");

        // Both requesters held: LS stores win until IF starvation forces a fetch.
        @(posedge clk); #1
        if_req = 1'b1; if_addr = 32'h20;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h10; ls_wdata = 32'hF;
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) push_ls(32'h10, 1'b1, 32'hF);
            else            push_if(32'h20, 1'b1);
        end
`else
        for (int k = 0; k < 10; k++) begin
            if (k == 4 || k == 9) push_if(32'h20, 1'b1);
            else                  push_ls(32'h10, 1'b1, 32'hF);
        end
`endif
        n = 0;
        for (int c = 0; c < 60 && n < 10; c++) begin
            @(negedge clk);
            if (if_gnt || ls_gnt) n++;
        end
        check("t3_grant_count", n, 10);
        @(posedge clk); #1 if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; ls_wdata = '0;
        wait_idle("t3");

        // Flush one cycle after an IF grant.
        @(posedge clk); #1 if_req = 1'b1; if_addr = 32'h40;
        push_if(32'h40, 1'b0);
        @(negedge clk);
        check("t4_gnt_T", if_gnt, 1);
        @(posedge clk); #1 if_req = 1'b0; if_flush = 1'b1;
        @(posedge clk); #1 if_flush = 1'b0;
        @(negedge clk);
        check("t4_no_rvalid_T2", if_rvalid, 0);
        check("t4_busy_T2", busy, 1);
        @(posedge clk); #1 if_req = 1'b1; if_addr = 32'h44;
        push_if(32'h44, 1'b1);
        @(negedge clk);
        check("t4_busy_T3", busy, 0);
        check("t4_regrant_T3", if_gnt, 1);
        @(posedge clk); #1 if_req = 1'b0;
        wait_idle("t4");

        // Flush in the issue cycle itself.
        @(posedge clk); #1 if_req = 1'b1; if_addr = 32'h48; if_flush = 1'b1;
        push_if(32'h48, 1'b0);
        @(posedge clk); #1 if_req = 1'b0; if_flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t4b_no_rvalid_T2", if_rvalid, 0);
        wait_idle("t4b");

        // Flush has no effect on an LS load.
        @(posedge clk); #1 ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h60;
        push_ls(32'h60, 1'b0, 32'h0);
        @(posedge clk); #1 ls_req = 1'b0; if_flush = 1'b1;
        @(posedge clk); #1 if_flush = 1'b0;
        @(negedge clk);
        check("t4c_ls_rvalid", ls_rvalid, 1);
        check("t4c_ls_rdata", ls_rdata, 32'h0060FF9F);
        wait_idle("t4c");

        // Reset in the middle of an LS load.
        @(posedge clk); #1 ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h80;
        exp_gnt.push_back('{1'b1, 32'h80, 1'b0, 32'h0});
        @(negedge clk);
        check("t5_gnt_T", ls_gnt, 1);
        @(posedge clk); #1 ls_req = 1'b0; reset_n = 1'b0;
        #1 check("t5_reset_outs_now", outs(), 0);
        @(negedge clk);
        check("t5_reset_outs_held", outs(), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1; ls_req = 1'b1; ls_addr = 32'h84;
        push_ls(32'h84, 1'b0, 32'h0);
        @(negedge clk);
        check("t5_first_cycle_outs", outs(), 0);
        @(negedge clk);
        check("t5_gnt_after_release", ls_gnt, 1);
        @(posedge clk); #1 ls_req = 1'b0;
        wait_idle("t5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
